// File: rtl/bit_deser.sv
// Serial-to-parallel capture stage: hunts for a sync word in the retimed bit
// stream, then packs following bits into WIDTH-bit words on a valid/ready port.
module bit_deser #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] SYNC      = WIDTH'(8'hA5),
   parameter bit               MSB_FIRST = 1'b1,
   parameter bit               INVERT    = 1'b1
) (
   input  logic                       clk,
   input  logic                       rb,
   input  logic                       en,
   input  logic                       clr,
   input  logic                       din,
   output logic [WIDTH-1:0]           dout,
   output logic                       dvalid,
   input  logic                       dready,
   output logic                       lock,
   output logic                       ovf,
   output logic [$clog2(WIDTH)-1:0]   bitcnt
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {HUNT, LOCK} state_t;

   state_t           state_reg,  state_next;
   logic [WIDTH-1:0] sr_reg,     sr_next;
   logic [WIDTH-1:0] dout_reg,   dout_next;
   logic             dvalid_reg, dvalid_next;
   logic             ovf_reg,    ovf_next;
   logic [CW-1:0]    bitcnt_reg, bitcnt_next;

   logic             b;
   logic [WIDTH-1:0] sr_shift;
   logic             complete;

   // The upstream retimer inverts the stream; INVERT undoes that here.
   assign b = din ^ INVERT;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign sr_shift = {sr_reg[WIDTH-2:0], b};
      end else begin : g_lsb_first
         assign sr_shift = {b, sr_reg[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rb) begin
      if (!rb) begin
         state_reg  <= HUNT;
         sr_reg     <= '0;
         dout_reg   <= '0;
         dvalid_reg <= 1'b0;
         ovf_reg    <= 1'b0;
         bitcnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         sr_reg     <= sr_next;
         dout_reg   <= dout_next;
         dvalid_reg <= dvalid_next;
         ovf_reg    <= ovf_next;
         bitcnt_reg <= bitcnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      sr_next     = sr_reg;
      dout_next   = dout_reg;
      dvalid_next = dvalid_reg;
      ovf_next    = ovf_reg;
      bitcnt_next = bitcnt_reg;
      complete    = 1'b0;

      if (clr) begin
         // dout is deliberately kept; only the control state is flushed.
         state_next  = HUNT;
         sr_next     = '0;
         dvalid_next = 1'b0;
         ovf_next    = 1'b0;
         bitcnt_next = '0;
      end else begin
         if (en) begin
            sr_next = sr_shift;
            case (state_reg)
               HUNT: begin
                  bitcnt_next = '0;
                  if (sr_shift == SYNC) begin
                     state_next = LOCK;
                  end
               end
               LOCK: begin
                  if (bitcnt_reg == LAST_BIT) begin
                     bitcnt_next = '0;
                     complete    = 1'b1;
                  end else begin
                     bitcnt_next = bitcnt_reg + CW'(1);
                  end
               end
               default: begin
                  state_next  = HUNT;
                  bitcnt_next = '0;
               end
            endcase
         end

         // A completed word may replace dout only if the old one is gone or leaving now.
         if (complete) begin
            if (!dvalid_reg || dready) begin
               dout_next   = sr_shift;
               dvalid_next = 1'b1;
            end else begin
               ovf_next = 1'b1;
            end
         end else if (dvalid_reg && dready) begin
            dvalid_next = 1'b0;
         end
      end
   end

   assign dout   = dout_reg;
   assign dvalid = dvalid_reg;
   assign lock   = (state_reg == LOCK);
   assign ovf    = ovf_reg;
   assign bitcnt = bitcnt_reg;

endmodule

// File: tb/tb_bit_deser.sv
// Directed bench for bit_deser (WIDTH=8, SYNC=A5, MSB first, inverted input)
// with a word scoreboard fed at stimulus time and drained at delivery.
module tb_bit_deser;

   logic       clk = 1'b0;
   logic       rb;
   logic       en;
   logic       clr;
   logic       din;
   logic [7:0] dout;
   logic       dvalid;
   logic       dready;
   logic       lock;
   logic       ovf;
   logic [2:0] bitcnt;

   int checks = 0;
   int passes = 0;
   logic [7:0] sb[$];

   bit_deser #(
      .WIDTH(8),
      .SYNC(8'hA5),
      .MSB_FIRST(1'b1),
      .INVERT(1'b1)
   ) dut (
      .clk(clk),
      .rb(rb),
      .en(en),
      .clr(clr),
      .din(din),
      .dout(dout),
      .dvalid(dvalid),
      .dready(dready),
      .lock(lock),
      .ovf(ovf),
      .bitcnt(bitcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock edge, then settle 1 time unit before sampling outputs.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Line bit is the complement of the logical bit because of the upstream inverter.
   task automatic send_bit(input logic bv);
      en  = 1'b1;
      din = ~bv;
      step();
      en  = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         send_bit(w[7 - i]);
      end
   endtask

   task automatic idle();
      en = 1'b0;
      step();
   endtask

   task automatic check_delivery(input string tag);
      logic [7:0] exp;
      if (sb.size() == 0) begin
         checks++;
         $error("FAIL %s: observed delivery %0h expected no pending word", tag, dout);
      end else begin
         exp = sb.pop_front();
         chk({tag, "_dvalid"}, 32'(dvalid), 32'd1);
         chk({tag, "_dout"}, 32'(dout), 32'(exp));
      end
      $display("word %s: dout=%02h dvalid=%0b ovf=%0b", tag, dout, dvalid, ovf);
   endtask

   initial begin
      logic [7:0] w;
      rb = 1'b0; en = 1'b0; clr = 1'b0; din = 1'b0; dready = 1'b0;
      step();
      step();
      rb = 1'b1;
      step();

      // Reset state
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_dvalid", 32'(dvalid), 32'h0);
      chk("rst_lock", 32'(lock), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      chk("rst_bitcnt", 32'(bitcnt), 32'h0);

      // Acquire sync after a few random bits
      for (int i = 0; i < 3; i++) begin
         send_bit(1'($urandom_range(0, 1)));
      end
      send_bits(8'hA5, 7);
      chk("hunt_nolock", 32'(lock), 32'h0);
      send_bits(8'hA5 << 7, 1);
      chk("sync_lock", 32'(lock), 32'h1);
      chk("sync_dvalid", 32'(dvalid), 32'h0);
      chk("sync_bitcnt", 32'(bitcnt), 32'h0);
      $display("sync: lock=%0b dvalid=%0b bitcnt=%0d", lock, dvalid, bitcnt);

      // Word 3C with dready=1
      dready = 1'b1;
      sb.push_back(8'h3C);
      send_bits(8'h3C, 3);
      chk("w3c_bitcnt3", 32'(bitcnt), 32'h3);
      send_bits(8'h3C << 3, 5);
      chk("w3c_bitcnt0", 32'(bitcnt), 32'h0);
      check_delivery("3C");
      idle();
      chk("w3c_drop", 32'(dvalid), 32'h0);

      // Same word with en toggling every other cycle
      sb.push_back(8'h3C);
      w = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         idle();
         send_bit(w[7 - i]);
         if (i == 6) chk("tog_notyet", 32'(dvalid), 32'h0);
      end
      check_delivery("3C_toggle");
      idle();
      chk("tog_drop", 32'(dvalid), 32'h0);

      // Back-to-back: 81 then 7E with dvalid held high throughout
      dready = 1'b1;
      sb.push_back(8'h81);
      send_bits(8'h81, 8);
      check_delivery("81");
      dready = 1'b0;
      sb.push_back(8'h7E);
      w = 8'h7E;
      for (int i = 0; i < 7; i++) begin
         send_bit(w[7 - i]);
      end
      chk("b2b_hold_valid", 32'(dvalid), 32'h1);
      chk("b2b_hold_dout", 32'(dout), 32'h81);
      dready = 1'b1;
      send_bit(w[0]);
      check_delivery("7E");
      chk("b2b_ovf", 32'(ovf), 32'h0);
      idle();
      chk("b2b_drop", 32'(dvalid), 32'h0);

      // Backpressure: 11 delivered, 22 dropped with overflow
      dready = 1'b0;
      sb.push_back(8'h11);
      send_bits(8'h11, 8);
      check_delivery("11");
      send_bits(8'h22, 8);
      chk("bp_dout", 32'(dout), 32'h11);
      chk("bp_dvalid", 32'(dvalid), 32'h1);
      chk("bp_ovf", 32'(ovf), 32'h1);
      dready = 1'b1;
      idle();
      chk("bp_xfer_dvalid", 32'(dvalid), 32'h0);
      chk("bp_xfer_ovf", 32'(ovf), 32'h1);
      $display("backpressure: dout=%02h dvalid=%0b ovf=%0b", dout, dvalid, ovf);

      // clr coincident with a word completion
      dready = 1'b0;
      send_bits(8'h5A, 7);
      clr = 1'b1;
      send_bit(1'b0);
      clr = 1'b0;
      chk("clr_lock", 32'(lock), 32'h0);
      chk("clr_dvalid", 32'(dvalid), 32'h0);
      chk("clr_ovf", 32'(ovf), 32'h0);
      chk("clr_bitcnt", 32'(bitcnt), 32'h0);
      chk("clr_dout_kept", 32'(dout), 32'h11);
      send_bits(8'hA5, 8);
      chk("relock", 32'(lock), 32'h1);
      sb.push_back(8'hC3);
      send_bits(8'hC3, 8);
      check_delivery("C3");

      // Asynchronous reset mid-cycle while locked with a pending word
      chk("pre_rst_lock", 32'(lock), 32'h1);
      #2;
      rb = 1'b0;
      #1;
      chk("arst_dout", 32'(dout), 32'h0);
      chk("arst_dvalid", 32'(dvalid), 32'h0);
      chk("arst_lock", 32'(lock), 32'h0);
      chk("arst_ovf", 32'(ovf), 32'h0);
      chk("arst_bitcnt", 32'(bitcnt), 32'h0);
      $display("async reset: dout=%02h dvalid=%0b lock=%0b", dout, dvalid, lock);
      step();
      rb = 1'b1;
      send_bits(8'h3C, 8);
      chk("post_rst_hunt", 32'(lock), 32'h0);
      chk("post_rst_nodata", 32'(dvalid), 32'h0);
      send_bits(8'hA5, 8);
      chk("post_rst_relock", 32'(lock), 32'h1);
      sb.push_back(8'h96);
      send_bits(8'h96, 8);
      check_delivery("96");

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/bit_deser.md
Name: bit_deser

Overview:
- Serial-to-parallel capture stage that sits directly downstream of the retiming circuit.
- Consumes that circuit's single-bit output `y`, which is launched on the falling edge of `clk` and is the inverted, one-cycle-delayed input stream.
- Samples the stream on the rising edge of `clk`, giving a half-cycle path for STA exercises.
- Hunts for a sync word, then packs subsequent bits into WIDTH-bit words presented on a valid/ready interface.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- SYNC, 8'hA5, sync pattern (WIDTH bits) that must be matched before words are delivered.
- MSB_FIRST, 1, 1: first received bit of a word lands in dout[WIDTH-1]; 0: first bit lands in dout[0].
- INVERT, 1, 1: sampled bit is complemented before use, undoing the upstream inverter.

Ports:
- clk  input  1  rising-edge clock.
- rb  input  1  asynchronous active-low reset.
- en  input  1  bit-enable; din is sampled only on edges with en=1.
- clr  input  1  synchronous clear; returns the block to HUNT.
- din  input  1  serial data (upstream y).
- dout  output  WIDTH  assembled word.
- dvalid  output  1  dout holds an undelivered word.
- dready  input  1  consumer accepts dout.
- lock  output  1  1 in LOCK state.
- ovf  output  1  sticky overflow flag.
- bitcnt  output  clog2(WIDTH)  bit index within the current word.

Behaviour:
- Reset (rb=0, asynchronous, effective immediately):
  - dout=0, dvalid=0, lock=0, ovf=0, bitcnt=0.
  - Shift register = 0, state=HUNT.
  - Release is synchronous to the next rising edge.
- Bit value b = din XOR INVERT.
  - Sampled only at rising edges with en=1 and clr=0.
  - Edges with en=0 change nothing except the handshake.
- Shift order:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], b}.
  - MSB_FIRST=0: sr <= {b, sr[WIDTH-1:1]}.
- State HUNT (lock=0):
  - Every enabled edge shifts b in.
  - If the post-shift window equals SYNC, go to LOCK at that edge and set bitcnt=0.
  - The sync word is never delivered.
  - bitcnt stays 0 throughout HUNT.
- State LOCK (lock=1):
  - Every enabled edge shifts b in and increments bitcnt.
  - On the edge sampling bit WIDTH-1, the word is complete: bitcnt wraps to 0.
  - The post-shift word is offered to the output register at that same edge.
  - Latency: dout/dvalid are visible immediately after the edge that samples the last bit.
  - LOCK is left only via clr or reset. There is no loss-of-lock detection.
- Output register / handshake:
  - A transfer occurs at a rising edge with dvalid=1 and dready=1.
  - Word complete, dvalid=0: load dout, dvalid<=1.
  - Word complete, dvalid=1, dready=1: load the new word, dvalid stays 1 (back-to-back, no bubble).
  - Word complete, dvalid=1, dready=0: new word dropped, dout unchanged, ovf<=1.
  - No completion, transfer occurs: dvalid<=0, dout holds its last value.
  - dout must not change while dvalid=1 and dready=0.
  - ovf stays set until clr or reset.
- clr=1 at an edge:
  - Highest synchronous priority, above completion and transfer.
  - state=HUNT, sr=0, bitcnt=0, dvalid=0, ovf=0. dout is not cleared.
- Reset mid-word: the partial word is discarded, and the block must re-acquire SYNC.
- dready is ignored while dvalid=0.
- All outputs are registered, with no combinational input-to-output path.

Test Plan (WIDTH=8, SYNC=8'hA5, MSB_FIRST=1, INVERT=1):
1. Pulse rb low mid-cycle with dvalid=1, lock=1 → all outputs read 0 before the next edge; state HUNT.
2. en=1, din serial 0,1,0,1,1,0,1,0 (that is, ~A5 MSB first) after 3 random-bit edges → lock rises after the 8th sync bit edge; dvalid remains 0; bitcnt=0.
3. From lock, din = bits of ~8'h3C, dready=1 → dvalid=1, dout=8'h3C right after the 8th edge; dvalid drops the next edge. Repeat with en toggling 0/1 every other cycle → same result, completion after 8 enabled edges only.
4. Backpressure: dready=0, send words 8'h11 then 8'h22 → dout stays 8'h11, dvalid=1, ovf=1 after the 16th edge. Then dready=1 for one edge → dvalid=0, ovf still 1.
5. Back-to-back: dready=1, send 8'h81, 8'h7E contiguously → dvalid high continuously; dout=8'h81 then 8'h7E on consecutive word boundaries; no ovf.
6. Assert clr on the same edge as a word completion with ovf=1 → lock=0, dvalid=0, ovf=0, bitcnt=0; the completed word is not presented; sending ~A5 again relocks.
